mem_stage: RTL and testbench

- Memory-access pipeline stage between the EX stage and the WB stage.
- Receives the ALU result and writeback info from EX. For loads, waits for the data-SRAM response, then extracts and extends the addressed byte, halfword or word.
- Hands the final result to WB through a valid/allow_in handshake.
- Publishes forwarding and load-stall information to ID.

---
 rtl/mem_stage_if.sv | 50 +++++
 rtl/mem_stage.sv | 124 ++++++++++++
 tb/tb_mem_stage.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Port bundle for the MEM stage: EX-side payload, WB handshake, data-SRAM response and ID forwarding.
// The slave modport is the stage itself; the master modport is whatever drives it (pipeline or bench).
interface mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int RF_AW  = 5
);
    // Handshake: a transfer EX->MEM happens on a clock where ex_to_mem_valid && mem_allow_in,
    // and MEM->WB where mem_to_wb_valid && wb_allow_in; valid may not depend on allow_in.
    logic              ex_to_mem_valid;
    logic              mem_allow_in;
    logic              wb_allow_in;
    logic              mem_to_wb_valid;

    logic [31:0]       ex_pc;
    logic [DATA_W-1:0] ex_alu_result;
    logic              ex_reg_we;
    logic [RF_AW-1:0]  ex_reg_waddr;
    logic [2:0]        ex_load_op;

    logic              data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;

    logic [31:0]       mem_pc;
    logic [DATA_W-1:0] mem_final_result;
    logic              mem_reg_we;
    logic [RF_AW-1:0]  mem_reg_waddr;

    logic              mem_fwd_valid;
    logic [RF_AW-1:0]  mem_fwd_waddr;
    logic [DATA_W-1:0] mem_fwd_data;
    logic              mem_load_busy;

    modport slave (
        input  ex_to_mem_valid, wb_allow_in,
        input  ex_pc, ex_alu_result, ex_reg_we, ex_reg_waddr, ex_load_op,
        input  data_sram_data_ok, data_sram_rdata,
        output mem_allow_in, mem_to_wb_valid,
        output mem_pc, mem_final_result, mem_reg_we, mem_reg_waddr,
        output mem_fwd_valid, mem_fwd_waddr, mem_fwd_data, mem_load_busy
    );

    modport master (
        output ex_to_mem_valid, wb_allow_in,
        output ex_pc, ex_alu_result, ex_reg_we, ex_reg_waddr, ex_load_op,
        output data_sram_data_ok, data_sram_rdata,
        input  mem_allow_in, mem_to_wb_valid,
        input  mem_pc, mem_final_result, mem_reg_we, mem_reg_waddr,
        input  mem_fwd_valid, mem_fwd_waddr, mem_fwd_data, mem_load_busy
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction from EX, waits for load data, extracts/extends it,
// hands the result to WB and publishes forwarding / load-stall info to ID.
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int RF_AW  = 5
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus
);
    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_LB   = 3'd1;
    localparam logic [2:0] OP_LBU  = 3'd2;
    localparam logic [2:0] OP_LH   = 3'd3;
    localparam logic [2:0] OP_LHU  = 3'd4;

    logic              mem_valid;
    logic              data_ok_r;
    logic [31:0]       pc_r;
    logic [DATA_W-1:0] alu_r;
    logic              reg_we_r;
    logic [RF_AW-1:0]  reg_waddr_r;
    logic [2:0]        load_op_r;
    logic [DATA_W-1:0] rdata_buf;

    logic              is_load;
    logic              mem_ready_go;
    logic              allow_in;
    logic              to_wb_valid;
    logic              leave;
    logic              buf_set;
    logic [DATA_W-1:0] raw;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] extracted;
    logic [DATA_W-1:0] final_result;

    assign is_load      = (load_op_r != OP_NONE);
    assign mem_ready_go = !is_load || data_ok_r || bus.data_sram_data_ok;
    assign allow_in     = !mem_valid || (mem_ready_go && bus.wb_allow_in);
    assign to_wb_valid  = mem_valid && mem_ready_go;
    assign leave        = to_wb_valid && bus.wb_allow_in;
    // Buffer the response only when WB cannot take it this cycle; stray or repeated data_ok is dropped.
    assign buf_set      = mem_valid && is_load && !data_ok_r && bus.data_sram_data_ok
                          && !bus.wb_allow_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid <= 1'b0;
        end else if (allow_in) begin
            mem_valid <= bus.ex_to_mem_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r        <= '0;
            alu_r       <= '0;
            reg_we_r    <= 1'b0;
            reg_waddr_r <= '0;
            load_op_r   <= OP_NONE;
        end else if (allow_in && bus.ex_to_mem_valid) begin
            pc_r        <= bus.ex_pc;
            alu_r       <= bus.ex_alu_result;
            reg_we_r    <= bus.ex_reg_we;
            reg_waddr_r <= bus.ex_reg_waddr;
            load_op_r   <= bus.ex_load_op;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_ok_r <= 1'b0;
            rdata_buf <= '0;
        end else begin
            if (leave) begin
                data_ok_r <= 1'b0;
            end else if (buf_set) begin
                data_ok_r <= 1'b1;
            end
            if (buf_set) begin
                rdata_buf <= bus.data_sram_rdata;
            end
        end
    end

    assign raw     = data_ok_r ? rdata_buf : bus.data_sram_rdata;
    // Halfword select uses a[1] only; misaligned halfwords are not trapped here.
    assign ld_half = alu_r[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        ld_byte = raw[7:0];
        case (alu_r[1:0])
            2'd0:    ld_byte = raw[7:0];
            2'd1:    ld_byte = raw[15:8];
            2'd2:    ld_byte = raw[23:16];
            default: ld_byte = raw[31:24];
        endcase
    end

    always_comb begin
        extracted = raw;
        case (load_op_r)
            OP_LB:   extracted = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  extracted = {24'd0, ld_byte};
            OP_LH:   extracted = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  extracted = {16'd0, ld_half};
            default: extracted = raw;
        endcase
    end

    assign final_result = is_load ? extracted : alu_r;

    assign bus.mem_allow_in     = allow_in;
    assign bus.mem_to_wb_valid  = to_wb_valid;
    assign bus.mem_pc           = pc_r;
    assign bus.mem_final_result = final_result;
    assign bus.mem_reg_we       = reg_we_r;
    assign bus.mem_reg_waddr    = reg_waddr_r;
    assign bus.mem_fwd_valid    = mem_valid && reg_we_r && (reg_waddr_r != '0) && mem_ready_go;
    assign bus.mem_fwd_waddr    = reg_waddr_r;
    assign bus.mem_fwd_data     = final_result;
    assign bus.mem_load_busy    = mem_valid && is_load && !mem_ready_go && reg_we_r;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: streaming, load extension, load wait, WB backpressure,
// forwarding and reset mid-load, with hand-computed expected values.
module tb_mem_stage;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    mem_stage_if #(.DATA_W(32), .RF_AW(5)) bus ();

    mem_stage #(.DATA_W(32), .RF_AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction from EX for a single cycle; MEM must be accepting.
    task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic we,
                         input logic [4:0] waddr, input logic [2:0] op);
        bus.ex_to_mem_valid = 1'b1;
        bus.ex_pc           = pc;
        bus.ex_alu_result   = alu;
        bus.ex_reg_we       = we;
        bus.ex_reg_waddr    = waddr;
        bus.ex_load_op      = op;
        #1;
        check("issue_allow_in", {31'd0, bus.mem_allow_in}, 32'd1);
        tick();
        bus.ex_to_mem_valid = 1'b0;
        #1;
    endtask

    // Load already in MEM: deliver data_ok with WB accepting and check the extracted result.
    task automatic load_resp(input string tag, input logic [31:0] rdata, input logic [31:0] exp);
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = rdata;
        #1;
        check({tag, "_valid"}, {31'd0, bus.mem_to_wb_valid}, 32'd1);
        check(tag, bus.mem_final_result, exp);
        tick();
        bus.data_sram_data_ok = 1'b0;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset                 = 1'b1;
        bus.ex_to_mem_valid   = 1'b0;
        bus.wb_allow_in       = 1'b1;
        bus.ex_pc             = '0;
        bus.ex_alu_result     = '0;
        bus.ex_reg_we         = 1'b0;
        bus.ex_reg_waddr      = '0;
        bus.ex_load_op        = '0;
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        check("rst_to_wb_valid", {31'd0, bus.mem_to_wb_valid}, 32'd0);
        check("rst_fwd_valid", {31'd0, bus.mem_fwd_valid}, 32'd0);
        check("rst_load_busy", {31'd0, bus.mem_load_busy}, 32'd0);
        check("rst_pc", bus.mem_pc, 32'd0);
        check("rst_result", bus.mem_final_result, 32'd0);
        check("rst_reg_we", {31'd0, bus.mem_reg_we}, 32'd0);
        check("rst_allow_in", {31'd0, bus.mem_allow_in}, 32'd1);

        // Non-load streaming at full throughput.
        bus.ex_to_mem_valid = 1'b1;
        bus.ex_reg_we       = 1'b1;
        bus.ex_reg_waddr    = 5'd3;
        bus.ex_load_op      = 3'd0;
        bus.ex_pc           = 32'h100;
        bus.ex_alu_result   = 32'h11;
        tick();
        bus.ex_pc         = 32'h104;
        bus.ex_alu_result = 32'h22;
        #1;
        check("stream0_valid", {31'd0, bus.mem_to_wb_valid}, 32'd1);
        check("stream0_result", bus.mem_final_result, 32'h11);
        check("stream0_pc", bus.mem_pc, 32'h100);
        check("stream0_allow", {31'd0, bus.mem_allow_in}, 32'd1);
        tick();
        bus.ex_pc         = 32'h108;
        bus.ex_alu_result = 32'h33;
        #1;
        check("stream1_valid", {31'd0, bus.mem_to_wb_valid}, 32'd1);
        check("stream1_result", bus.mem_final_result, 32'h22);
        check("stream1_allow", {31'd0, bus.mem_allow_in}, 32'd1);
        tick();
        bus.ex_to_mem_valid = 1'b0;
        #1;
        check("stream2_valid", {31'd0, bus.mem_to_wb_valid}, 32'd1);
        check("stream2_result", bus.mem_final_result, 32'h33);
        tick();
        check("stream_done_valid", {31'd0, bus.mem_to_wb_valid}, 32'd0);

        // Load extraction: rdata 0x80FF7F01.
        issue(32'h200, 32'h1003, 1'b1, 5'd4, 3'd1);
        load_resp("lb", 32'h80FF7F01, 32'hFFFFFF80);
        issue(32'h204, 32'h1003, 1'b1, 5'd4, 3'd2);
        load_resp("lbu", 32'h80FF7F01, 32'h00000080);
        issue(32'h208, 32'h1002, 1'b1, 5'd4, 3'd3);
        load_resp("lh", 32'h80FF7F01, 32'hFFFF80FF);
        issue(32'h20C, 32'h1002, 1'b1, 5'd4, 3'd4);
        load_resp("lhu", 32'h80FF7F01, 32'h000080FF);
        issue(32'h210, 32'h1000, 1'b1, 5'd4, 3'd5);
        load_resp("lw", 32'h80FF7F01, 32'h80FF7F01);
        issue(32'h214, 32'h1001, 1'b1, 5'd4, 3'd1);
        load_resp("lb_a1", 32'h80FF7F01, 32'h0000007F);
        issue(32'h218, 32'h1000, 1'b1, 5'd4, 3'd7);
        load_resp("op7_lw", 32'h80FF7F01, 32'h80FF7F01);

        // Load waiting three cycles for data.
        issue(32'h300, 32'h2000, 1'b1, 5'd7, 3'd5);
        for (int i = 0; i < 3; i++) begin
            check("wait_busy", {31'd0, bus.mem_load_busy}, 32'd1);
            check("wait_allow", {31'd0, bus.mem_allow_in}, 32'd0);
            check("wait_to_wb", {31'd0, bus.mem_to_wb_valid}, 32'd0);
            tick();
        end
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h0BADF00D;
        #1;
        check("wait_done_busy", {31'd0, bus.mem_load_busy}, 32'd0);
        check("wait_done_fwd", {31'd0, bus.mem_fwd_valid}, 32'd1);
        load_resp("wait_done", 32'h0BADF00D, 32'h0BADF00D);

        // WB backpressure while data returns.
        issue(32'h400, 32'h3000, 1'b1, 5'd8, 3'd5);
        bus.wb_allow_in       = 1'b0;
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'hDEADBEEF;
        #1;
        check("bp_resp_valid", {31'd0, bus.mem_to_wb_valid}, 32'd1);
        tick();
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = 32'h12345678;
        #1;
        check("bp_hold0_result", bus.mem_final_result, 32'hDEADBEEF);
        check("bp_hold0_valid", {31'd0, bus.mem_to_wb_valid}, 32'd1);
        check("bp_hold0_allow", {31'd0, bus.mem_allow_in}, 32'd0);
        tick();
        bus.data_sram_rdata = 32'h55AA55AA;
        #1;
        check("bp_hold1_result", bus.mem_final_result, 32'hDEADBEEF);
        bus.wb_allow_in = 1'b1;
        #1;
        check("bp_release_result", bus.mem_final_result, 32'hDEADBEEF);
        check("bp_release_allow", {31'd0, bus.mem_allow_in}, 32'd1);
        tick();
        check("bp_gone_valid", {31'd0, bus.mem_to_wb_valid}, 32'd0);

        // Next load must wait again, proving the buffered response was cleared; then reset mid-load.
        issue(32'h500, 32'h4000, 1'b1, 5'd9, 3'd5);
        check("rl_busy", {31'd0, bus.mem_load_busy}, 32'd1);
        check("rl_to_wb", {31'd0, bus.mem_to_wb_valid}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'hCAFEF00D;
        #1;
        check("rl_late_to_wb", {31'd0, bus.mem_to_wb_valid}, 32'd0);
        check("rl_late_fwd", {31'd0, bus.mem_fwd_valid}, 32'd0);
        check("rl_late_busy", {31'd0, bus.mem_load_busy}, 32'd0);
        check("rl_late_reg_we", {31'd0, bus.mem_reg_we}, 32'd0);
        tick();
        bus.data_sram_data_ok = 1'b0;
        #1;
        check("rl_after_to_wb", {31'd0, bus.mem_to_wb_valid}, 32'd0);
        check("rl_after_allow", {31'd0, bus.mem_allow_in}, 32'd1);

        // Forwarding.
        issue(32'h600, 32'h55, 1'b1, 5'd5, 3'd0);
        check("fwd_r5_valid", {31'd0, bus.mem_fwd_valid}, 32'd1);
        check("fwd_r5_waddr", {27'd0, bus.mem_fwd_waddr}, 32'd5);
        check("fwd_r5_data", bus.mem_fwd_data, 32'h55);
        issue(32'h604, 32'h66, 1'b1, 5'd0, 3'd0);
        check("fwd_r0_valid", {31'd0, bus.mem_fwd_valid}, 32'd0);
        check("fwd_r0_to_wb", {31'd0, bus.mem_to_wb_valid}, 32'd1);
        tick();
        check("bubble_fwd_valid", {31'd0, bus.mem_fwd_valid}, 32'd0);
        check("bubble_busy", {31'd0, bus.mem_load_busy}, 32'd0);
        check("bubble_fwd_waddr", {27'd0, bus.mem_fwd_waddr}, 32'd0);
        check("bubble_to_wb", {31'd0, bus.mem_to_wb_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
